pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central pipeline sequencing controller for the 5-stage CPU. It drives the PC write enable, the IF/ID write and flush controls, the ID/EX bubble insert and a global freeze. These outputs handle load-use hazards, ID-stage taken branches and a multi-cycle data-memory request/acknowledge handshake with timeout. It also keeps saturating stall and flush performance counters. It sits beside the hazard-aware PC and pipeline registers and is their only source of stall and flush control.

## Interface
- MEM_TIMEOUT, 64: maximum consecutive unacknowledged data-memory request cycles before error (≥2).
- CNT_W, 16: width of the performance counters.

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  run request, sampled only in IDLE
- id_rs_i  in  5  rs field of the instruction in ID
- id_rt_i  in  5  rt field of the instruction in ID
- id_uses_rt_i  in  1  the ID instruction reads rt
- ex_memread_i  in  1  the EX instruction is a load
- ex_rt_i  in  5  destination register of the EX load
- branch_taken_i  in  1  ID-stage branch/jump resolved taken
- dmem_req_i  in  1  the MEM stage is accessing data memory this cycle
- dmem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID load enable
- ifid_flush_o  out  1  IF/ID load NOP
- idex_bubble_o  out  1  ID/EX load control-zero bubble
- freeze_o  out  1  hold all pipeline registers (ID/EX, EX/MEM, MEM/WB)
- err_o  out  1  memory timeout error, sticky
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0 while in RUN or MEM_WAIT
- flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1

## Operation
- States: IDLE, RUN, MEM_WAIT, ERROR. Reset enters IDLE.
- IDLE:
  - All enables are 0: pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o and freeze_o.
  - start_i=1 moves to RUN.
- Signals derived in RUN:
  - mem_stall = dmem_req_i & ~dmem_ack_i.
  - load_use = ex_memread_i & (ex_rt_i≠0) & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- RUN output priority, highest first:
  1. mem_stall: freeze_o=1, pc_write_o=0, ifid_write_o=0, no bubble, no flush. Next state MEM_WAIT, wait_cnt←1.
  2. load_use: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, freeze_o=0, flush suppressed even if branch_taken_i=1. The branch re-resolves next cycle.
  3. branch_taken_i: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1.
  4. Otherwise: pc_write_o=1, ifid_write_o=1, all other outputs 0.
- MEM_WAIT:
  - Without ack: freeze_o=1 and all enables 0.
  - dmem_ack_i=1: the cycle behaves exactly as RUN with mem_stall=0 (load_use and branch evaluated normally). Next state RUN.
  - No ack with wait_cnt==MEM_TIMEOUT−1: next state ERROR.
  - No ack otherwise: wait_cnt increments.
- ERROR:
  - freeze_o=1, err_o=1, all enables 0.
  - Exit only by reset. start_i is ignored.
- start_i is ignored outside IDLE.
- Counters:
  - Saturate at all-ones and clear only on reset.
  - stall_cnt_o increments each RUN or MEM_WAIT cycle with pc_write_o=0.
  - flush_cnt_o increments each cycle with ifid_flush_o=1.

## Timing
- Reset values: state IDLE, err_o=0, stall_cnt_o=0, flush_cnt_o=0, wait_cnt=0. All other outputs are 0.
- Enables are combinational from state and inputs, with zero latency.
- err_o is registered: it goes high the cycle after the final unacked cycle.
- Start latency: start_i=1 in cycle N gives the first pc_write_o=1 in cycle N+1.
- Load-use stall lasts one cycle. The bubble clears ex_memread_i the next cycle, so the hazard does not re-fire.
- Timeout rule:
  - err_o rises after MEM_TIMEOUT consecutive unacked request cycles, counting the RUN entry cycle.
  - An ack in the MEM_TIMEOUT-th cycle still succeeds.
- Back-to-back requests: a new dmem_req_i without ack in the cycle after an ack re-enters MEM_WAIT with wait_cnt←1.
- Reset asserted mid-MEM_WAIT or in ERROR: immediate return to IDLE with all outputs 0.

## Test plan
- Reset, hold start_i=0 for 5 cycles -> all enables 0. Pulse start_i -> pc_write_o=1 from the next cycle, with stall_cnt_o=0 during IDLE.
- In RUN, ex_memread_i=1, ex_rt_i=5, id_rs_i=5 -> exactly one cycle with pc_write_o=0 and idex_bubble_o=1, stall_cnt_o=1. Repeat with ex_rt_i=0 -> no stall.
- load_use and branch_taken_i together -> bubble, no flush. Next cycle with branch only -> ifid_flush_o=1, flush_cnt_o=1.
- dmem_req_i=1 with dmem_ack_i delayed 3 cycles -> freeze_o=1 for 3 cycles, deasserted on the ack cycle, state RUN afterwards, err_o=0.
- MEM_TIMEOUT=4, request never acked -> freeze_o=1 throughout and err_o=1 from the 5th cycle. err_o stays high through start_i pulses and clears only on rst_i=0.
- Force 2^CNT_W+3 stall cycles (e.g. CNT_W=4) -> stall_cnt_o saturates at 15 and does not wrap.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequences the 5-stage pipeline. It resolves load-use, taken-branch and data-memory
// stalls into PC/IF-ID/ID-EX/freeze controls, and keeps saturating stall and flush counters.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             freeze_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_ONE = WW'(1);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, ERROR} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic            mem_stall, load_use, issue;

  assign mem_stall = dmem_req_i & ~dmem_ack_i;
  assign load_use  = ex_memread_i & (ex_rt_i != 5'd0) &
                     ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
  // A cycle issues normally from RUN without a memory stall, or from MEM_WAIT on the ack cycle.
  assign issue = ((state_q == RUN) & ~mem_stall) | ((state_q == MEM_WAIT) & dmem_ack_i);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    err_d         = err_q;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    if (issue) begin
      idex_bubble_o = load_use;
      pc_write_o    = ~load_use;
      ifid_write_o  = ~load_use;
      ifid_flush_o  = ~load_use & branch_taken_i;
    end
    case (state_q)
      IDLE: state_d = start_i ? RUN : IDLE;
      RUN: begin
        if (mem_stall) begin
          freeze_o = 1'b1;
          state_d  = MEM_WAIT;
          wait_d   = WAIT_ONE;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = RUN;
        end else begin
          freeze_o = 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_ONE;
          end
        end
      end
      default: freeze_o = 1'b1;
    endcase
    stall_d = (((state_q == RUN) | (state_q == MEM_WAIT)) & ~pc_write_o & ~&stall_q) ?
              stall_q + 1'b1 : stall_q;
    flush_d = (ifid_flush_o & ~&flush_q) ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
endmodule
